// File: rtl/input_debouncer.sv
// Debouncer for a raw asynchronous level input.
// din passes through a short synchroniser. A four-state FSM then accepts a new
// level only after DEBOUNCE_CYCLES consecutive synchronised samples agree.
// Aborted candidate changes are counted in a saturating glitch counter.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  output logic                dout,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   din_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
  logic                   glitch_inc;

  // Shift din into the synchroniser chain; only the last stage is used.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  assign din_s = sync_q[SYNC_STAGES-1];

  // Qualification FSM. The counter holds how many agreeing samples have been
  // seen in the current check, so the last one lands on CNT_LAST.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    glitch_inc = 1'b0;
    unique case (state_q)
      STABLE_LOW: begin
        if (din_s) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK_HIGH: begin
        if (!din_s) begin
          state_d    = STABLE_LOW;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          dout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!din_s) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK_LOW: begin
        if (din_s) begin
          state_d    = STABLE_HIGH;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          dout_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
  end

  // Glitch counter sticks at all-ones instead of wrapping.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_inc && !(&glitch_q)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  // State registers; reset aborts any check without counting a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign dout       = dout_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus a random run, checked
// against a run-length reference model of the debounce rules.
module tb_input_debouncer;

  localparam int SS   = 2;
  localparam int DC   = 4;
  localparam int GW   = 8;
  localparam int GMAX = (1 << GW) - 1;
  localparam int PER  = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          din2 = 1'b0;
  logic          dout, busy;
  logic [GW-1:0] glitch_cnt;
  logic          dout2, busy2;
  logic [1:0]    gc2;

  int checks = 0;
  int errors = 0;

  input_debouncer #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .GLITCH_W(GW)) u_dut (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout), .busy(busy), .glitch_cnt(glitch_cnt)
  );

  input_debouncer #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .GLITCH_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din2),
    .dout(dout2), .busy(busy2), .glitch_cnt(gc2)
  );

  always #(PER/2) clk = ~clk;

  // Reference model: delay din by SS samples, then track how many consecutive
  // delayed samples disagree with the accepted level. DC disagreements flip
  // the level; a disagreement run that ends early is one glitch.
  logic [SS-1:0] m_pipe = '0;
  logic          m_dout = 1'b0;
  int            m_run  = 0;
  int            m_gl   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pipe <= '0;
      m_dout <= 1'b0;
      m_run  <= 0;
      m_gl   <= 0;
    end else begin
      m_pipe <= {m_pipe[SS-2:0], din};
      if (m_pipe[SS-1] != m_dout) begin
        if (m_run + 1 >= DC) begin
          m_dout <= m_pipe[SS-1];
          m_run  <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else if (m_run != 0) begin
        m_run <= 0;
        if (m_gl < GMAX) m_gl <= m_gl + 1;
      end
    end
  end

  // Downstream rising-edge detector fed by dout.
  logic d_prev = 1'b0;
  logic re_pulse = 1'b0;
  always @(posedge clk) begin
    d_prev   <= dout;
    re_pulse <= dout & ~d_prev;
  end

  task automatic test_reset();
    int rise;
    @(negedge clk);
    rst = 1'b1;
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dout !== 1'b0 || busy !== 1'b0 || glitch_cnt !== '0) begin
        errors++;
        $display("FAIL reset_vals cyc%0d: dout=%b busy=%b glitch=%0d, need 0/0/0",
                 i, dout, busy, glitch_cnt);
      end
    end
    rst  = 1'b0;
    rise = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (dout === 1'b1 && rise == 0) rise = i;
    end
    checks++;
    if (rise != SS + DC) begin
      errors++;
      $display("FAIL reset_rise_edge: got edge %0d, need %0d", rise, SS + DC);
    end
    din = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (dout !== m_dout || glitch_cnt !== GW'(m_gl)) begin
      errors++;
      $display("FAIL reset_settle: dout=%b glitch=%0d, need %b/%0d", dout, glitch_cnt, m_dout, m_gl);
    end
  endtask

  task automatic test_clean();
    for (int lvl = 1; lvl >= 0; lvl--) begin
      int edge_at, busy_n;
      din     = lvl[0];
      edge_at = 0;
      busy_n  = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (busy === 1'b1) busy_n++;
        if (dout === lvl[0] && edge_at == 0) edge_at = i;
      end
      checks++;
      if (edge_at != SS + DC) begin
        errors++;
        $display("FAIL clean_edge lvl%0d: got edge %0d, need %0d", lvl, edge_at, SS + DC);
      end
      checks++;
      if (busy_n != DC - 1) begin
        errors++;
        $display("FAIL clean_busy lvl%0d: busy cycles %0d, need %0d", lvl, busy_n, DC - 1);
      end
      checks++;
      if (glitch_cnt !== '0) begin
        errors++;
        $display("FAIL clean_glitch lvl%0d: glitch=%0d, need 0", lvl, glitch_cnt);
      end
    end
  endtask

  task automatic test_glitch();
    int g0;
    g0 = m_gl;
    // 3 ns pulse far from any rising edge: never sampled.
    @(negedge clk);
    #5 din = 1'b1;
    #3 din = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (glitch_cnt !== GW'(g0) || dout !== 1'b0) begin
      errors++;
      $display("FAIL glitch_3ns: glitch=%0d dout=%b, need %0d/0", glitch_cnt, dout, g0);
    end
    for (int w = 1; w <= 3; w += 2) begin
      din = 1'b1;
      repeat (w) @(negedge clk);
      din = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (glitch_cnt !== GW'(g0 + (w + 1) / 2) || dout !== 1'b0) begin
        errors++;
        $display("FAIL glitch_w%0d: glitch=%0d dout=%b, need %0d/0", w, glitch_cnt, dout, g0 + (w + 1) / 2);
      end
    end
  endtask

  task automatic test_boundary();
    int g0;
    logic saw_high;
    g0 = m_gl;
    saw_high = 1'b0;
    din = 1'b1;
    repeat (DC) @(negedge clk);
    din = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dout === 1'b1) saw_high = 1'b1;
    end
    checks++;
    if (saw_high !== 1'b1 || glitch_cnt !== GW'(g0)) begin
      errors++;
      $display("FAIL boundary_exact: saw_high=%b glitch=%0d, need 1/%0d", saw_high, glitch_cnt, g0);
    end
    saw_high = 1'b0;
    din = 1'b1;
    repeat (DC - 1) @(negedge clk);
    din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dout === 1'b1) saw_high = 1'b1;
    end
    checks++;
    if (saw_high !== 1'b0 || glitch_cnt !== GW'(g0 + 1)) begin
      errors++;
      $display("FAIL boundary_short: saw_high=%b glitch=%0d, need 0/%0d", saw_high, glitch_cnt, g0 + 1);
    end
  endtask

  task automatic test_mid_reset();
    din = 1'b1;
    repeat (SS + 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_checking: busy=%b, need 1", busy);
    end
    rst = 1'b1;
    din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || dout !== 1'b0 || glitch_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_abort: busy=%b dout=%b glitch=%0d, need 0/0/0", busy, dout, glitch_cnt);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dout !== 1'b0 || glitch_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_after: busy=%b dout=%b glitch=%0d, need 0/0/0", busy, dout, glitch_cnt);
    end
  endtask

  task automatic test_chain();
    int g0, pulses;
    g0 = m_gl;
    pulses = 0;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          din = 1'b1;
          repeat (2) @(negedge clk);
          din = 1'b0;
          @(negedge clk);
        end
        din = 1'b1;
      end
      begin
        for (int i = 0; i < 25; i++) begin
          @(negedge clk);
          if (re_pulse === 1'b1) pulses++;
        end
      end
    join
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL chain_pulses: got %0d rising pulses, need 1", pulses);
    end
    checks++;
    if (dout !== 1'b1 || glitch_cnt !== GW'(g0 + 3)) begin
      errors++;
      $display("FAIL chain_state: dout=%b glitch=%0d, need 1/%0d", dout, glitch_cnt, g0 + 3);
    end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 5; k++) begin
      int exp;
      exp = (k < 3) ? k : 3;
      din2 = 1'b1;
      @(negedge clk);
      din2 = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (gc2 !== 2'(exp) || dout2 !== 1'b0) begin
        errors++;
        $display("FAIL sat_pulse%0d: glitch=%0d dout=%b, need %0d/0", k, gc2, dout2, exp);
      end
    end
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (dout !== m_dout || busy !== (m_run != 0) || glitch_cnt !== GW'(m_gl)) begin
        errors++;
        $display("FAIL random cyc%0d: dout=%b busy=%b glitch=%0d, need %b/%b/%0d",
                 i, dout, busy, glitch_cnt, m_dout, (m_run != 0), m_gl);
      end
      if (left == 0) begin
        din  = ~din;
        left = $urandom_range(1, 2 * DC);
      end
      left--;
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_boundary();
    test_mid_reset();
    test_chain();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
